// File: rtl/gpiox_if.sv
// gpiox_if: peripheral bus bundle between a bus master and the gpiox slave
interface gpiox_if #(parameter int ARCHBITSZ = 32);
   localparam int AW = ARCHBITSZ - $clog2(ARCHBITSZ/8);
   logic                   wb_cyc_i;
   logic                   wb_stb_i;
   logic                   wb_we_i;
   logic [AW-1:0]          wb_addr_i;
   logic [ARCHBITSZ/8-1:0] wb_sel_i;
   logic [ARCHBITSZ-1:0]   wb_dat_i;
   logic                   wb_bsy_o;
   logic                   wb_ack_o;
   logic [ARCHBITSZ-1:0]   wb_dat_o;
   logic [ARCHBITSZ-1:0]   wb_mapsz_o;
   modport master(output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i,
                  input wb_bsy_o, wb_ack_o, wb_dat_o, wb_mapsz_o);
   modport slave(input wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i,
                 output wb_bsy_o, wb_ack_o, wb_dat_o, wb_mapsz_o);
endinterface

// File: rtl/gpiox.sv
// gpiox: GPIO controller with direction, set/clr/tgl, debounce and edge interrupts
module gpiox #(
   parameter int ARCHBITSZ = 32,
   parameter int CLKFREQ   = 1,
   parameter int IOCOUNT   = 1,
   parameter int DBNCBITSZ = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   gpiox_if.slave             bus,
   output logic               irq_stb_o,
   input  logic               irq_rdy_i,
   input  logic [IOCOUNT-1:0] i,
   output logic [IOCOUNT-1:0] o,
   output logic [IOCOUNT-1:0] t
);
   localparam int NB = ARCHBITSZ/8;
   logic                 req_q, we_q, rdy_q, wr;
   logic [3:0]           adr_q;
   logic [NB-1:0]        sel_q;
   logic [ARCHBITSZ-1:0] dat_q, bm, d, rd;
   logic [IOCOUNT-1:0]   ien, rise, fall, isr, s0, s1, deb, deb_p, ev, w1c;
   logic [DBNCBITSZ-1:0] dbnc;
   logic [DBNCBITSZ-1:0] cnt [IOCOUNT];
   function automatic logic [ARCHBITSZ-1:0] mrg(input logic [ARCHBITSZ-1:0] old);
      return (dat_q & bm) | (old & ~bm);
   endfunction
   always_comb begin
      for (int k = 0; k < NB; k++) bm[k*8 +: 8] = {8{sel_q[k]}};
   end
   assign d   = dat_q & bm;
   assign wr  = req_q & we_q;
   assign ev  = ((deb & ~deb_p & rise) | (~deb & deb_p & fall)) & ien & ~t;
   assign w1c = (wr && adr_q == 4'd8) ? IOCOUNT'(d) : '0;
   assign bus.wb_bsy_o   = 1'b0;
   assign bus.wb_mapsz_o = ARCHBITSZ'(16*NB);
   always_comb begin
      case (adr_q)
         4'd0:             rd = ARCHBITSZ'((t & o) | (~t & deb));
         4'd1, 4'd2, 4'd3: rd = ARCHBITSZ'(o);
         4'd4:             rd = ARCHBITSZ'(t);
         4'd5:             rd = ARCHBITSZ'(ien);
         4'd6:             rd = ARCHBITSZ'(rise);
         4'd7:             rd = ARCHBITSZ'(fall);
         4'd8:             rd = ARCHBITSZ'(isr);
         4'd9:             rd = ARCHBITSZ'(dbnc);
         4'd10:            rd = ARCHBITSZ'(IOCOUNT);
         4'd11:            rd = ARCHBITSZ'(CLKFREQ);
         default:          rd = '0;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_q <= 1'b0;
         we_q <= 1'b0;
         adr_q <= '0;
         sel_q <= '0;
         dat_q <= '0;
         bus.wb_ack_o <= 1'b0;
         bus.wb_dat_o <= '0;
         o <= '0;
         t <= '0;
         ien <= '0;
         rise <= '0;
         fall <= '0;
         isr <= '0;
         dbnc <= '0;
         irq_stb_o <= 1'b0;
         rdy_q <= 1'b0;
      end else begin
         req_q <= bus.wb_cyc_i & bus.wb_stb_i;
         we_q <= bus.wb_we_i;
         adr_q <= bus.wb_addr_i[3:0];
         sel_q <= bus.wb_sel_i;
         dat_q <= bus.wb_dat_i;
         bus.wb_ack_o <= req_q;
         bus.wb_dat_o <= req_q ? rd : '0;
         if (wr)
            case (adr_q)
               4'd0: o <= IOCOUNT'(mrg(ARCHBITSZ'(o)));
               4'd1: o <= o | IOCOUNT'(d);
               4'd2: o <= o & ~IOCOUNT'(d);
               4'd3: o <= o ^ IOCOUNT'(d);
               4'd4: t <= IOCOUNT'(mrg(ARCHBITSZ'(t)));
               4'd5: ien <= IOCOUNT'(mrg(ARCHBITSZ'(ien)));
               4'd6: rise <= IOCOUNT'(mrg(ARCHBITSZ'(rise)));
               4'd7: fall <= IOCOUNT'(mrg(ARCHBITSZ'(fall)));
               4'd9: dbnc <= DBNCBITSZ'(mrg(ARCHBITSZ'(dbnc)));
               default: ;
            endcase
         // a new event outranks both the software clear and the acknowledge
         isr <= (isr & ~w1c) | ev;
         irq_stb_o <= (|ev) | (irq_stb_o & ~(rdy_q & ~irq_rdy_i));
         rdy_q <= irq_rdy_i;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s0 <= '0;
         s1 <= '0;
         deb <= '0;
         deb_p <= '0;
         for (int k = 0; k < IOCOUNT; k++) cnt[k] <= '0;
      end else begin
         s0 <= i;
         s1 <= s0;
         deb_p <= deb;
         for (int k = 0; k < IOCOUNT; k++)
            if (s1[k] == deb[k]) cnt[k] <= '0;
            else if (cnt[k] == dbnc) begin
               deb[k] <= s1[k];
               cnt[k] <= '0;
            end else cnt[k] <= cnt[k] + DBNCBITSZ'(1);
      end
   end
endmodule

// File: doc/gpiox.md
# gpiox

Parametrised GPIO controller with per-pin direction, atomic set/clear/toggle of outputs, programmable debounce, and per-pin edge-selectable interrupts with a write-1-to-clear status register. It sits on the peripheral bus as a memory-mapped slave, next to the existing GPIO block. It drives one interrupt line to the interrupt controller through the standard stb/rdy pair.

## Interface
- ARCHBITSZ, 32: bus data width; 16, 32 or 64.
- CLKFREQ, 1: clk_i frequency in Hz; reported in register 11.
- IOCOUNT, 1: number of pins; 1..ARCHBITSZ.
- DBNCBITSZ, 16: width of the debounce threshold and of each per-pin counter.

- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i, wb_stb_i  in  1  request qualifiers; a request is cyc&stb.
- wb_we_i  in  1  1 = write.
- wb_addr_i  in  ARCHBITSZ-clog2(ARCHBITSZ/8)  word address; bits [3:0] select the register.
- wb_sel_i  in  ARCHBITSZ/8  write byte enables.
- wb_dat_i  in  ARCHBITSZ  write data.
- wb_bsy_o  out  1  tied 0.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_dat_o  out  ARCHBITSZ  read data; valid while wb_ack_o is high.
- wb_mapsz_o  out  ARCHBITSZ  constant 16*(ARCHBITSZ/8).
- irq_stb_o  out  1  interrupt request.
- irq_rdy_i  in  1  a falling edge acknowledges the request.
- i  in  IOCOUNT  pad inputs (asynchronous).
- o  out  IOCOUNT  pad output values.
- t  out  IOCOUNT  per-pin direction; 1 = output.

## Operation
- Register map (word index → access):
  - 0 DATA: read returns (t&o)|(~t&deb); write loads o.
  - 1 SET: write performs o |= d.
  - 2 CLR: write performs o &= ~d.
  - 3 TGL: write performs o ^= d.
  - 4 DIR: read/write t.
  - 5 IEN: read/write interrupt enable.
  - 6 RISE: read/write rising-edge select.
  - 7 FALL: read/write falling-edge select.
  - 8 ISR: read status; writing 1 clears the bit.
  - 9 DBNC: read/write threshold [DBNCBITSZ-1:0].
  - 10 INFO: read-only IOCOUNT.
  - 11 FREQ: read-only CLKFREQ, truncated to ARCHBITSZ.
  - 12-15: read 0; writes ignored.
- Reads of SET, CLR and TGL return o.
- Byte enables:
  - Data bytes with wb_sel_i=0 are treated as 0 for SET, CLR, TGL and ISR.
  - For DATA, DIR, IEN, RISE, FALL and DBNC, the register bytes under disabled lanes are left unchanged.
- Bits at or above IOCOUNT read 0 and ignore writes.
- Input path, per pin:
  - 2-flop synchroniser, then a debouncer holding a stable value deb and a counter.
  - If sync==deb, the counter clears.
  - Otherwise the counter increments. When counter==DBNC, deb<=sync and the counter clears.
  - With DBNC=0, deb follows sync one cycle later.
- Events:
  - rise = deb & ~deb_prev; fall = ~deb & deb_prev.
  - ev = (rise&RISE | fall&FALL) & IEN & ~t.
  - Each cycle ISR <= (ISR & ~w1c) | ev. If a set and a clear hit the same bit in the same cycle, the set wins.
- Interrupt:
  - irq_stb_o sets on any nonzero ev.
  - irq_stb_o clears on a falling edge of irq_rdy_i, unless ev is nonzero in that same cycle, in which case it stays 1.
  - ISR bits are cleared only by software.
- Reset values: o, t, IEN, RISE, FALL, ISR, DBNC, the counters, deb, deb_prev, the synchronisers and irq_stb_o are all 0. wb_ack_o=0 and wb_dat_o=0.

## Timing
- Request sampled at edge E0 (address, we, data, sel registered).
- Write takes effect at edge E1.
- wb_ack_o is high for exactly the cycle after E1, with read data valid in that cycle.
- Back-to-back requests every cycle are allowed; each request gets its own ack, two cycles later.
- Reads return register state as of E1. DATA reflects deb as registered at E1.
- Pin change to deb: 2 synchroniser cycles + DBNC + 1 cycles.
- deb change to ISR bit: 1 cycle. irq_stb_o is set in the same cycle as the ISR bit.
- Reset asserted mid-transaction: a pending ack is dropped; no register update.
- A write to DIR that turns a pin into an output suppresses events for that pin from the next cycle.
- A DBNC write takes effect immediately. A counter already above the new threshold waits for the next counter==DBNC, which occurs after counter wrap-around at 2^DBNCBITSZ.

## Test plan
- Reset, then read all 16 words:
  - INFO = IOCOUNT; FREQ = CLKFREQ; every other word 0; wb_mapsz_o = 64 at ARCHBITSZ=32.
  - Each ack arrives exactly 2 cycles after its request.
- Output updates with IOCOUNT=8:
  - Write DATA=0xA5 → o=0xA5.
  - SET 0x0F → o=0xAF.
  - CLR 0xA0 → o=0x0F.
  - TGL 0xFF → o=0xF0.
  - SET 0xFF with wb_sel_i=0 → o unchanged.
- Debounce with DBNC=4: a 3-cycle glitch on i[0] → deb unchanged, no event; a 10-cycle pulse → deb rises, with the latency given under Timing.
- Interrupt edge select:
  - IEN=0x3, RISE=0x1, FALL=0x2.
  - Rise on pin0 → ISR=0x1, irq_stb_o=1.
  - Rise on pin1 → ISR unchanged.
  - Fall on pin1 → ISR=0x3.
  - Write ISR=0x1 → ISR=0x2.
- Interrupt acknowledge and simultaneous events:
  - A falling edge of irq_rdy_i clears irq_stb_o.
  - A falling edge coinciding with an event keeps irq_stb_o=1.
  - A W1C coinciding with a new event on the same bit leaves that bit set.
- Direction masking and mid-transaction reset:
  - With t=1 on a pin, toggling i produces no ISR change, and DATA returns o for that pin.
  - Asserting rst_i one cycle after a write request → no ack, register stays at 0.
